// File: rtl/sram_like_axi_bridge_pkg.sv
// Shared types for the SRAM-like to AXI bridge: AXI request/response bundles,
// bridge FSM states, burst/size encodings and the SRAM-size to AXI-size helper.
package sram_like_axi_bridge_pkg;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [2:0] AXI_SIZE_BYTE  = 3'd0;
   localparam logic [2:0] AXI_SIZE_HALF  = 3'd1;
   localparam logic [2:0] AXI_SIZE_WORD  = 3'd2;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_ADDR = 3'd1,
      RD_DATA = 3'd2,
      WR_ADDR = 3'd3,
      WR_DATA = 3'd4,
      WR_RESP = 3'd5
   } bridge_state_e;

   typedef struct packed {
      logic [3:0]  arid;
      logic [31:0] araddr;
      logic [7:0]  arlen;
      logic [2:0]  arsize;
      logic [1:0]  arburst;
      logic [1:0]  arlock;
      logic [3:0]  arcache;
      logic [2:0]  arprot;
      logic        arvalid;
      logic        rready;
      logic [3:0]  awid;
      logic [31:0] awaddr;
      logic [7:0]  awlen;
      logic [2:0]  awsize;
      logic [1:0]  awburst;
      logic [1:0]  awlock;
      logic [3:0]  awcache;
      logic [2:0]  awprot;
      logic        awvalid;
      logic [3:0]  wid;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        wlast;
      logic        wvalid;
      logic        bready;
   } axi_req_t;

   typedef struct packed {
      logic        arready;
      logic [3:0]  rid;
      logic [31:0] rdata;
      logic [1:0]  rresp;
      logic        rlast;
      logic        rvalid;
      logic        awready;
      logic        wready;
      logic [3:0]  bid;
      logic [1:0]  bresp;
      logic        bvalid;
   } axi_resp_t;

   // The SRAM side has no 8-byte access; encoding 3 is folded onto a word.
   function automatic logic [2:0] axi_size(input logic [1:0] sz);
      return (sz == 2'd3) ? AXI_SIZE_WORD : {1'b0, sz};
   endfunction

endpackage

// File: rtl/sram_like_wstrb_decode.sv
// Byte-lane strobe decode for a single SRAM-like access from its size and the
// low two address bits; lanes that would fall past the word are dropped.
module sram_like_wstrb_decode (
   input  logic [1:0] size,
   input  logic [1:0] addr_lo,
   output logic [3:0] wstrb
);

   always_comb begin
      wstrb = 4'b1111;
      case (size)
         2'd0:    wstrb = 4'b0001 << addr_lo;
         2'd1:    wstrb = 4'b0011 << addr_lo;
         default: wstrb = 4'b1111;
      endcase
   end

endmodule

// File: rtl/sram_like_axi_bridge.sv
// Single-outstanding SRAM-like to AXI master bridge. Defining
// SRAM_LIKE_AXI_BRIDGE_AW_W_PARALLEL_EN issues AW and W together from WR_ADDR.
module sram_like_axi_bridge
   import sram_like_axi_bridge_pkg::*;
#(
   parameter logic [3:0] AXI_ID = 4'd0
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          req,
   input  logic          wr,
   input  logic [1:0]    size,
   input  logic [31:0]   addr,
   input  logic [31:0]   wdata,
   output logic          addr_ok,
   output logic          data_ok,
   output logic [31:0]   rdata,
   output axi_req_t      axi_req,
   input  axi_resp_t     axi_resp,
   output bridge_state_e dbg_state
);

   // Handshakes: a transfer happens on any cycle where valid and ready are both
   // high; a raised valid is held, with its payload, until that cycle.
   bridge_state_e state_q, state_d;
   logic          wr_q, wr_d;
   logic [1:0]    size_q, size_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [3:0]    wstrb;
`ifdef SRAM_LIKE_AXI_BRIDGE_AW_W_PARALLEL_EN
   logic          aw_done_q, aw_done_d;
   logic          w_done_q, w_done_d;
`endif

   sram_like_wstrb_decode u_wstrb (
      .size    (size_q),
      .addr_lo (addr_q[1:0]),
      .wstrb   (wstrb)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q   <= IDLE;
         wr_q      <= 1'b0;
         size_q    <= 2'd0;
         addr_q    <= 32'd0;
         wdata_q   <= 32'd0;
`ifdef SRAM_LIKE_AXI_BRIDGE_AW_W_PARALLEL_EN
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         wr_q      <= wr_d;
         size_q    <= size_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
`ifdef SRAM_LIKE_AXI_BRIDGE_AW_W_PARALLEL_EN
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      wr_d      = wr_q;
      size_d    = size_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
`ifdef SRAM_LIKE_AXI_BRIDGE_AW_W_PARALLEL_EN
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
`endif
      case (state_q)
         IDLE: begin
            if (req) begin
               wr_d    = wr;
               size_d  = size;
               addr_d  = addr;
               wdata_d = wdata;
               state_d = wr ? WR_ADDR : RD_ADDR;
            end
         end
         RD_ADDR: if (axi_resp.arready) state_d = RD_DATA;
         RD_DATA: if (axi_resp.rvalid)  state_d = IDLE;
         WR_ADDR: begin
`ifdef SRAM_LIKE_AXI_BRIDGE_AW_W_PARALLEL_EN
            // Each channel's done flag latches its own handshake; leave once both have fired.
            aw_done_d = aw_done_q | axi_resp.awready;
            w_done_d  = w_done_q  | axi_resp.wready;
            if (aw_done_d && w_done_d) begin
               state_d   = WR_RESP;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
            end
`else
            if (axi_resp.awready) state_d = WR_DATA;
`endif
         end
         WR_DATA: if (axi_resp.wready) state_d = WR_RESP;
         WR_RESP: if (axi_resp.bvalid) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      addr_ok         = 1'b0;
      data_ok         = 1'b0;
      rdata           = 32'd0;
      axi_req         = '0;
      axi_req.arid    = AXI_ID;
      axi_req.araddr  = addr_q;
      axi_req.arsize  = axi_size(size_q);
      axi_req.arburst = AXI_BURST_INCR;
      axi_req.awid    = AXI_ID;
      axi_req.awaddr  = addr_q;
      axi_req.awsize  = axi_size(size_q);
      axi_req.awburst = AXI_BURST_INCR;
      axi_req.wid     = AXI_ID;
      axi_req.wdata   = wdata_q;
      axi_req.wstrb   = wstrb;
      axi_req.wlast   = 1'b1;
      // Reset masks every strobe combinationally, even before the state flop clears.
      if (resetn) begin
         case (state_q)
            IDLE:    addr_ok = req;
            RD_ADDR: axi_req.arvalid = 1'b1;
            RD_DATA: begin
               axi_req.rready = 1'b1;
               if (axi_resp.rvalid) begin
                  data_ok = 1'b1;
                  rdata   = axi_resp.rdata;
               end
            end
            WR_ADDR: begin
`ifdef SRAM_LIKE_AXI_BRIDGE_AW_W_PARALLEL_EN
               axi_req.awvalid = !aw_done_q;
               axi_req.wvalid  = !w_done_q;
`else
               axi_req.awvalid = 1'b1;
`endif
            end
            WR_DATA: axi_req.wvalid = 1'b1;
            WR_RESP: begin
               axi_req.bready = 1'b1;
               data_ok        = axi_resp.bvalid;
            end
            default: ;
         endcase
      end
   end

   assign dbg_state = state_q;

   // Response codes and IDs are deliberately ignored; the direction is carried by the state.
   logic unused_bits;
   assign unused_bits = ^{wr_q, axi_resp.rid, axi_resp.rresp, axi_resp.rlast,
                          axi_resp.bid, axi_resp.bresp};

endmodule

// File: tb/tb_sram_like_axi_bridge.sv
// Bench for sram_like_axi_bridge: write-attribute vector table, directed corner
// sequences and randomized transactions against a latency/strobe reference model.
module tb_sram_like_axi_bridge;
   import sram_like_axi_bridge_pkg::*;

   logic          clk = 1'b0;
   logic          resetn;
   logic          req;
   logic          wr;
   logic [1:0]    size;
   logic [31:0]   addr;
   logic [31:0]   wdata;
   logic          addr_ok;
   logic          data_ok;
   logic [31:0]   rdata;
   axi_req_t      axi_req;
   axi_resp_t     axi_resp;
   bridge_state_e dbg_state;

   int tests  = 0;
   int failed = 0;
   int dok_cnt = 0;

   sram_like_axi_bridge #(.AXI_ID(4'd0)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .req       (req),
      .wr        (wr),
      .size      (size),
      .addr      (addr),
      .wdata     (wdata),
      .addr_ok   (addr_ok),
      .data_ok   (data_ok),
      .rdata     (rdata),
      .axi_req   (axi_req),
      .axi_resp  (axi_resp),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   // Counts every data_ok pulse, including any that appear outside a transaction.
   always @(negedge clk) begin
      #2;
      if (data_ok) dok_cnt++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] model_strb(input logic [1:0] sz, input logic [1:0] a);
      int n;
      int base;
      logic [3:0] m;
      n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      base = (n == 4) ? 0 : int'(a);
      m    = 4'b0000;
      for (int i = 0; i < 4; i++)
         if (i >= base && i < base + n) m[i] = 1'b1;
      return m;
   endfunction

   function automatic int model_latency(input logic t_wr, input int ar_d, input int r_d,
                                        input int aw_d, input int w_d, input int b_d);
      if (!t_wr) return 2 + ar_d + r_d;
`ifdef SRAM_LIKE_AXI_BRIDGE_AW_W_PARALLEL_EN
      return 2 + ((aw_d > w_d) ? aw_d : w_d) + b_d;
`else
      return 3 + aw_d + w_d + b_d;
`endif
   endfunction

   task automatic check_quiet(input string tag);
      check({tag, "_addr_ok"}, addr_ok, 1'b0);
      check({tag, "_data_ok"}, data_ok, 1'b0);
      check({tag, "_rdata"}, rdata, 32'd0);
      check({tag, "_valids"}, {axi_req.arvalid, axi_req.rready, axi_req.awvalid,
                               axi_req.wvalid, axi_req.bready}, 5'b0);
   endtask

   // One transaction: slave waits *_d cycles of valid before answering.
   task automatic run_txn(input logic t_wr, input logic [1:0] t_size, input logic [31:0] t_addr,
                          input logic [31:0] t_wdata, input logic [31:0] t_rdata,
                          input int ar_d, input int r_d, input int aw_d, input int w_d,
                          input int b_d, input logic keep_req,
                          output logic [2:0] seen_size, output logic [3:0] seen_strb);
      int lat, exp_lat, ar_c, r_c, aw_c, w_c, b_c, aw_cyc, w_cyc;
      logic aw_hs, w_hs, done;
      logic [2:0] exp_size;
      logic [3:0] exp_strb;
      exp_size = (t_size == 2'd3) ? 3'd2 : {1'b0, t_size};
      exp_strb = model_strb(t_size, t_addr[1:0]);
      exp_lat  = model_latency(t_wr, ar_d, r_d, aw_d, w_d, b_d);
      lat = -1; ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0; aw_cyc = 0; w_cyc = 0;
      aw_hs = 1'b0; w_hs = 1'b0; done = 1'b0; seen_size = 3'd7; seen_strb = 4'b0;
      @(negedge clk);
      req = 1'b1; wr = t_wr; size = t_size; addr = t_addr; wdata = t_wdata;
      axi_resp = '0;
      #1;
      check("addr_ok_accept", addr_ok, 1'b1);
      check("data_ok_at_accept", data_ok, 1'b0);
      for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
         @(negedge clk);
         if (keep_req) begin
            req = 1'b1; wr = 1'($urandom); size = 2'($urandom); addr = $urandom; wdata = $urandom;
         end else begin
            req = 1'b0;
         end
         if (axi_req.arvalid) ar_c++;
         if (axi_req.rready)  r_c++;
         if (axi_req.awvalid) aw_c++;
         if (axi_req.wvalid)  w_c++;
         if (axi_req.bready)  b_c++;
         axi_resp.arready = axi_req.arvalid && (ar_c > ar_d);
         axi_resp.rvalid  = axi_req.rready  && (r_c > r_d);
         axi_resp.rdata   = axi_resp.rvalid ? t_rdata : $urandom;
         axi_resp.rresp   = 2'($urandom);
         axi_resp.awready = axi_req.awvalid && (aw_c > aw_d);
         axi_resp.wready  = axi_req.wvalid  && (w_c > w_d);
         axi_resp.bvalid  = axi_req.bready  && (b_c > b_d);
         axi_resp.bresp   = 2'($urandom);
         #1;
         check("addr_ok_busy", addr_ok, 1'b0);
         if (axi_req.arvalid) begin
            check("araddr", axi_req.araddr, t_addr);
            check("ar_attr", {axi_req.arsize, axi_req.arlen, axi_req.arburst, axi_req.arid},
                  {exp_size, 8'd0, 2'b01, 4'd0});
         end
         if (axi_req.awvalid) begin
            aw_cyc++;
            seen_size = axi_req.awsize;
            check("awaddr", axi_req.awaddr, t_addr);
            check("aw_attr", {axi_req.awsize, axi_req.awlen, axi_req.awburst, axi_req.awcache},
                  {exp_size, 8'd0, 2'b01, 4'd0});
         end
         if (axi_req.wvalid) begin
            w_cyc++;
            seen_strb = axi_req.wstrb;
            check("w_payload", {axi_req.wstrb, axi_req.wlast, axi_req.wdata},
                  {exp_strb, 1'b1, t_wdata});
         end
         if (axi_req.bready) check("bready_after_both", {aw_hs, w_hs}, 2'b11);
         if (data_ok) begin
            lat  = cyc;
            done = 1'b1;
            if (!t_wr) check("rdata", rdata, t_rdata);
         end
         if (axi_req.awvalid && axi_resp.awready) aw_hs = 1'b1;
         if (axi_req.wvalid && axi_resp.wready)   w_hs  = 1'b1;
      end
      check("latency", 32'(lat), 32'(exp_lat));
      if (t_wr) check("aw_w_valid_cycles", {16'(aw_cyc), 16'(w_cyc)}, {16'(aw_d + 1), 16'(w_d + 1)});
   endtask

   typedef struct {
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  exp_awsize;
      logic [3:0]  exp_wstrb;
   } wvec_t;

   wvec_t vecs[7];

   initial begin
      logic [2:0] s_size;
      logic [3:0] s_strb;
      int dok0;
      vecs[0] = '{2'd0, 32'h8000_0003, 32'hAB00_0000, 3'd0, 4'b1000};
      vecs[1] = '{2'd0, 32'h8000_0100, 32'h0000_00CD, 3'd0, 4'b0001};
      vecs[2] = '{2'd0, 32'h8000_0101, 32'h0000_EF00, 3'd0, 4'b0010};
      vecs[3] = '{2'd1, 32'h8000_0202, 32'h1234_0000, 3'd1, 4'b1100};
      vecs[4] = '{2'd1, 32'h8000_0200, 32'h0000_5678, 3'd1, 4'b0011};
      vecs[5] = '{2'd2, 32'h8000_0307, 32'hCAFE_F00D, 3'd2, 4'b1111};
      vecs[6] = '{2'd3, 32'h8000_0404, 32'h0BAD_CAFE, 3'd2, 4'b1111};

      resetn = 1'b0; req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h1000; wdata = 32'd0;
      axi_resp = '0;
      repeat (2) @(negedge clk);
      #1;
      check_quiet("reset");
      check("reset_state", 32'(dbg_state), 32'(IDLE));
      @(negedge clk);
      resetn = 1'b1; req = 1'b0;

      // Single read with an immediately ready slave: data_ok two cycles after acceptance.
      run_txn(1'b0, 2'd2, 32'h1FC0_0004, 32'd0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 1'b0, s_size, s_strb);

      for (int i = 0; i < 7; i++) begin
         run_txn(1'b1, vecs[i].size, vecs[i].addr, vecs[i].wdata, 32'd0,
                 0, 0, 0, 0, i % 3, 1'b0, s_size, s_strb);
         check("vec_awsize", s_size, vecs[i].exp_awsize);
         check("vec_wstrb", s_strb, vecs[i].exp_wstrb);
      end

      // Address backpressure with req held high throughout.
      run_txn(1'b0, 2'd2, 32'h0000_1230, 32'd0, 32'h5555_AAAA, 5, 0, 0, 0, 0, 1'b1, s_size, s_strb);

      // AW delayed against an immediate W.
      run_txn(1'b1, 2'd2, 32'h0000_2000, 32'h7777_8888, 32'd0, 0, 0, 3, 0, 0, 1'b0, s_size, s_strb);

      // Back-to-back read then write with req never dropping.
      @(negedge clk);
      dok0 = dok_cnt;
      run_txn(1'b0, 2'd1, 32'h0000_3002, 32'd0, 32'h0000_BEEF, 1, 1, 0, 0, 0, 1'b1, s_size, s_strb);
      run_txn(1'b1, 2'd0, 32'h0000_3001, 32'h0000_4400, 32'd0, 0, 0, 1, 1, 1, 1'b1, s_size, s_strb);
      @(negedge clk);
      req = 1'b0; axi_resp = '0;
      repeat (3) @(negedge clk);
      check("b2b_data_ok_pulses", 32'(dok_cnt - dok0), 32'd2);

      // Reset while a write waits on W; nothing may complete afterwards.
      @(negedge clk);
      dok0 = dok_cnt;
      req = 1'b1; wr = 1'b1; size = 2'd2; addr = 32'h0000_4000; wdata = 32'h0101_0101;
      axi_resp = '0;
      #1 check("rst_wr_accept", addr_ok, 1'b1);
      @(negedge clk);
      req = 1'b0; axi_resp.awready = 1'b1;
      @(negedge clk);
      axi_resp = '0;
      #1;
`ifdef SRAM_LIKE_AXI_BRIDGE_AW_W_PARALLEL_EN
      check("rst_pending_w", {axi_req.awvalid, axi_req.wvalid}, 2'b01);
`else
      check("rst_in_wr_data", 32'(dbg_state), 32'(WR_DATA));
`endif
      @(negedge clk);
      resetn = 1'b0;
      #1 check_quiet("rst_during");
      @(negedge clk);
      resetn = 1'b1; axi_resp.wready = 1'b1; axi_resp.bvalid = 1'b1;
      #1;
      check("rst_state_idle", 32'(dbg_state), 32'(IDLE));
      check_quiet("rst_after");
      repeat (4) @(negedge clk);
      #1 check("rst_still_idle", 32'(dbg_state), 32'(IDLE));
      axi_resp = '0;
      @(negedge clk);
      check("rst_no_data_ok", 32'(dok_cnt - dok0), 32'd0);

      for (int n = 0; n < 30; n++) begin
         run_txn(1'($urandom), 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom), s_size, s_strb);
      end
      @(negedge clk);
      req = 1'b0; axi_resp = '0;
      repeat (2) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
